// File: rtl/ldpc_sched_pkg.sv
// rtl/ldpc_sched_pkg.sv - shared widths, LLR type and FSM states for the LDPC layer scheduler
package ldpc_sched_pkg;

  localparam int NUM_LAYERS      = 8;
  localparam int NUM_COLS        = 16;
  localparam int WIDTH_LLR       = 8;
  localparam int WIDTH_ITERATION = 4;
  localparam int TIMEOUT         = 64;
  localparam int LAYER_W         = $clog2(NUM_LAYERS);
  localparam int COL_W           = $clog2(NUM_COLS);
  localparam int TIMER_W         = $clog2(TIMEOUT);

  typedef logic signed [WIDTH_LLR-1:0] llr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/ldpc_llr_buf.sv
// rtl/ldpc_llr_buf.sv - NUM_COLS x WIDTH_LLR LLR register file, per-column write enable, flat read bus
module ldpc_llr_buf #(
  parameter int NUM_COLS  = 16,
  parameter int WIDTH_LLR = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COLS-1:0]           we,
  input  logic [NUM_COLS*WIDTH_LLR-1:0] wdata,
  output logic [NUM_COLS*WIDTH_LLR-1:0] rdata
);

  logic [NUM_COLS*WIDTH_LLR-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (we[c]) mem_q[c*WIDTH_LLR +: WIDTH_LLR] <= wdata[c*WIDTH_LLR +: WIDTH_LLR];
      end
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/ldpc_layer_sched.sv
// rtl/ldpc_layer_sched.sv - layer scheduler and LLR buffer driving one check node
// Optional sign-stability early termination: LDPC_SCHED_EARLY_STOP_EN
module ldpc_layer_sched
  import ldpc_sched_pkg::*;
#(
  parameter logic [NUM_LAYERS*NUM_COLS-1:0] LAYER_MASK = '1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startIn,
  input  logic [WIDTH_ITERATION-1:0]    maxIter,
  input  logic                          loadValid,
  input  llr_t                          loadLlr,
  output logic                          LoadReady,
  output logic                          ChknValid,
  output logic [LAYER_W-1:0]            ChknLayer,
  output logic [WIDTH_ITERATION-1:0]    ChknIter,
  output logic [NUM_COLS-1:0]           ChknActive,
  output logic [NUM_COLS*WIDTH_LLR-1:0] ChknLlr,
  output logic [NUM_COLS*WIDTH_LLR-1:0] ChknEtaSum,
  input  logic                          chknValidIn,
  input  logic [NUM_COLS*WIDTH_LLR-1:0] chknEtaSumIn,
  output logic [NUM_COLS-1:0]           DecBits,
  output logic [WIDTH_ITERATION-1:0]    IterUsed,
  output logic                          ValidOut,
  output logic                          Busy,
  output logic                          Error
);

  state_e                        state_q, state_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [LAYER_W-1:0]            layer_q, layer_d;
  logic [WIDTH_ITERATION-1:0]    iter_q, iter_d, max_q, max_d, used_q, used_d;
  logic [TIMER_W-1:0]            timer_q, timer_d;
  logic                          err_q, err_d;
  logic [NUM_COLS-1:0]           dec_q, dec_d;
  logic [NUM_COLS-1:0]           buf_we, signs, layer_mask;
  logic [NUM_COLS*WIDTH_LLR-1:0] buf_wdata, buf_rdata;
  logic                          early_stop;

  ldpc_llr_buf #(.NUM_COLS(NUM_COLS), .WIDTH_LLR(WIDTH_LLR)) u_buf (
    .clk  (clk),
    .rst_n(reset),
    .we   (buf_we),
    .wdata(buf_wdata),
    .rdata(buf_rdata)
  );

  assign layer_mask = LAYER_MASK[layer_q*NUM_COLS +: NUM_COLS];

  always_comb begin
    signs = '0;
    for (int c = 0; c < NUM_COLS; c++) signs[c] = buf_rdata[c*WIDTH_LLR + WIDTH_LLR-1];
  end

`ifdef LDPC_SCHED_EARLY_STOP_EN
  logic [NUM_COLS-1:0] snap_q, new_signs;

  // Signs the buffer will hold once the current response has been merged in.
  always_comb begin
    new_signs = signs;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (layer_mask[c]) new_signs[c] = chknEtaSumIn[c*WIDTH_LLR + WIDTH_LLR-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snap_q <= '0;
    else if (state_q == ISSUE && layer_q == '0) snap_q <= signs;
  end

  assign early_stop = (new_signs == snap_q) && (iter_q >= WIDTH_ITERATION'(2));
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      layer_q <= '0;
      iter_q  <= '0;
      max_q   <= '0;
      used_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      layer_q <= layer_d;
      iter_q  <= iter_d;
      max_q   <= max_d;
      used_q  <= used_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    layer_d   = layer_q;
    iter_d    = iter_q;
    max_d     = max_q;
    used_d    = used_q;
    timer_d   = timer_q;
    err_d     = err_q;
    dec_d     = dec_q;
    buf_we    = '0;
    buf_wdata = chknEtaSumIn;
    case (state_q)
      IDLE: begin
        if (startIn) begin
          max_d   = (maxIter == '0) ? WIDTH_ITERATION'(1) : maxIter;
          err_d   = 1'b0;
          col_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        buf_wdata = {NUM_COLS{loadLlr}};
        if (loadValid) begin
          buf_we[col_q] = 1'b1;
          col_d         = col_q + 1'b1;
          if (col_q == COL_W'(NUM_COLS-1)) begin
            layer_d = '0;
            iter_d  = WIDTH_ITERATION'(1);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (chknValidIn) begin
          buf_we = layer_mask;
          if (layer_q != LAYER_W'(NUM_LAYERS-1)) begin
            layer_d = layer_q + 1'b1;
            state_d = ISSUE;
          end else if (!early_stop && iter_q < max_q) begin
            layer_d = '0;
            iter_d  = iter_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        dec_d   = signs;
        used_d  = iter_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE presents live results; the _q copies hold them until the next frame ends.
  assign ValidOut   = (state_q == DONE);
  assign DecBits    = ValidOut ? signs : dec_q;
  assign IterUsed   = ValidOut ? iter_q : used_q;
  assign LoadReady  = (state_q == LOAD);
  assign Busy       = (state_q != IDLE);
  assign Error      = err_q;
  assign ChknValid  = (state_q == ISSUE);
  assign ChknLayer  = layer_q;
  assign ChknIter   = iter_q;
  assign ChknActive = (state_q == ISSUE || state_q == WAIT) ? layer_mask : '0;
  assign ChknLlr    = buf_rdata;
  assign ChknEtaSum = buf_rdata;

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// tb/tb_ldpc_layer_sched.sv - table-driven frame bench for ldpc_layer_sched
module tb_ldpc_layer_sched;

  // Layer l mask: even layers 16'h00FF, odd layers 16'h000F; columns 8..15 never active.
  localparam logic [127:0] MASK = {16'h000F, 16'h00FF, 16'h000F, 16'h00FF,
                                   16'h000F, 16'h00FF, 16'h000F, 16'h00FF};
`ifdef LDPC_SCHED_EARLY_STOP_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  logic         clk, reset, startIn, loadValid, chknValidIn;
  logic [3:0]   maxIter;
  logic [7:0]   loadLlr;
  logic         LoadReady, ChknValid, ValidOut, Busy, Error;
  logic [2:0]   ChknLayer;
  logic [3:0]   ChknIter, IterUsed;
  logic [15:0]  ChknActive, DecBits;
  logic [127:0] ChknLlr, ChknEtaSum, chknEtaSumIn;

  int checks = 0;
  int errors = 0;

  ldpc_layer_sched #(.LAYER_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .startIn(startIn), .maxIter(maxIter),
    .loadValid(loadValid), .loadLlr(loadLlr), .LoadReady(LoadReady),
    .ChknValid(ChknValid), .ChknLayer(ChknLayer), .ChknIter(ChknIter),
    .ChknActive(ChknActive), .ChknLlr(ChknLlr), .ChknEtaSum(ChknEtaSum),
    .chknValidIn(chknValidIn), .chknEtaSumIn(chknEtaSumIn), .DecBits(DecBits),
    .IterUsed(IterUsed), .ValidOut(ValidOut), .Busy(Busy), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  max_iter;
    logic [7:0]  load_val;
    int          mode;      // 0 echo request, 1 constant response, 2 no response
    logic [7:0]  resp_val;
    bit          abort;
    logic [15:0] exp_dec;
    logic [3:0]  exp_iter;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mask_of(input int l);
    logic [127:0] m;
    m = MASK;
    return m[l*16 +: 16];
  endfunction

  function automatic logic all_outs_zero();
    return ~|{LoadReady, ChknValid, ChknLayer, ChknIter, ChknActive, ChknLlr, ChknEtaSum,
              DecBits, IterUsed, ValidOut, Busy, Error};
  endfunction

  task automatic run_frame(input vec_t v);
    int col, cyc, reqs, last_req, cnt, exp_layer, exp_it;
    bit pending, done;
    logic [127:0] req_llr;
    startIn = 1'b1;
    maxIter = v.max_iter;
    @(posedge clk); #1;
    startIn = 1'b0;
    chk("load_ready", LoadReady, 1'b1);
    chk("error_cleared", Error, 1'b0);
    col = 0;
    cyc = 0;
    // Cycle 3 is a load gap carrying a stray response that must be ignored.
    while (col < 16 && cyc < 200) begin
      loadLlr      = v.load_val;
      loadValid    = (cyc != 3);
      chknValidIn  = (cyc == 3);
      chknEtaSumIn = {16{8'h80}};
      @(posedge clk); #1;
      if (loadValid) col++;
      cyc++;
    end
    loadValid   = 1'b0;
    chknValidIn = 1'b0;
    chk("load_count", col, 16);
    reqs = 0; exp_layer = 0; exp_it = 1; pending = 0; done = 0; cyc = 0; last_req = 0; cnt = 0;
    req_llr = '0;
    while (!done && cyc < 3000) begin
      chknValidIn = 1'b0;
      if (ChknValid) begin
        reqs++;
        chk("req_layer", ChknLayer, exp_layer);
        chk("req_iter", ChknIter, exp_it);
        chk("req_active", ChknActive, mask_of(exp_layer));
        req_llr  = ChknLlr;
        last_req = cyc;
        pending  = 1'b1;
        cnt      = 2;
        if (v.abort && ChknIter == 4'd2) begin
          @(posedge clk); #1;
          reset = 1'b0;
          #1;
          chk("abort_outputs_zero", all_outs_zero(), 1'b1);
          @(negedge clk);
          reset = 1'b1;
          @(posedge clk); #1;
          chk("abort_idle", {Busy, ValidOut}, 2'b00);
          return;
        end
        exp_layer++;
        if (exp_layer == 8) begin
          exp_layer = 0;
          exp_it++;
        end
      end else if (pending && v.mode != 2) begin
        cnt--;
        if (cnt == 0) begin
          chknValidIn  = 1'b1;
          chknEtaSumIn = (v.mode == 0) ? req_llr : {16{v.resp_val}};
          pending      = 1'b0;
        end
      end
      if (ValidOut) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chknValidIn = 1'b0;
    chk("frame_completed", done, 1'b1);
    chk("dec_bits", DecBits, v.exp_dec);
    chk("iter_used", IterUsed, v.exp_iter);
    chk("error", Error, v.exp_err);
    chk("request_count", reqs, v.exp_err ? 1 : 8 * v.exp_iter);
    if (v.exp_err) chk("timeout_latency", cyc - last_req, 65);
    @(posedge clk); #1;
    chk("done_hold", {Busy, ValidOut, DecBits, IterUsed}, {2'b00, v.exp_dec, v.exp_iter});
  endtask

  initial begin
    vecs[0] = '{4'd1, 8'd5,    0, 8'd0,    1'b0, 16'h0000, 4'd1, 1'b0};
    vecs[1] = '{4'd1, 8'hFD,   1, 8'd7,    1'b0, 16'hFF00, 4'd1, 1'b0};
    vecs[2] = '{4'd3, 8'hFE,   0, 8'd0,    1'b0, 16'hFFFF, ES ? 4'd2 : 4'd3, 1'b0};
    vecs[3] = '{4'd0, 8'd1,    1, 8'hFF,   1'b0, 16'h00FF, 4'd1, 1'b0};
    vecs[4] = '{4'd3, 8'hFA,   0, 8'd0,    1'b1, 16'h0000, 4'd0, 1'b0};
    vecs[5] = '{4'd5, 8'hF7,   0, 8'd0,    1'b0, 16'hFFFF, ES ? 4'd2 : 4'd5, 1'b0};
    vecs[6] = '{4'd2, 8'd4,    2, 8'd0,    1'b0, 16'h0000, 4'd1, 1'b1};
    vecs[7] = '{4'd2, 8'd3,    0, 8'd0,    1'b0, 16'h0000, 4'd2, 1'b0};

    reset = 1'b0; startIn = 1'b0; maxIter = '0; loadValid = 1'b0; loadLlr = '0;
    chknValidIn = 1'b0; chknEtaSumIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", all_outs_zero(), 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {Busy, LoadReady, ValidOut}, 3'b000);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
